// File: rtl/uncached_write_buffer_if.sv
// Store-port and DDR AF/WDF-port signals of the uncached write buffer.
// The DQ_W parameter must match the buffer instance that uses this bundle.
interface uncached_write_buffer_if #(
    parameter int DQ_W = 128
) ();
    logic [31:0]       addr;
    logic [31:0]       din;
    logic [3:0]        we;
    logic              af_full;
    logic              wdf_full;
    logic              stall;
    logic              empty;
    logic [30:0]       af_addr_din;
    logic              af_wr_en;
    logic [DQ_W-1:0]   wdf_din;
    logic [DQ_W/8-1:0] wdf_mask_din;
    logic              wdf_wr_en;

    modport slave (
        input  addr, din, we, af_full, wdf_full,
        output stall, empty, af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
    );

    modport master (
        output addr, din, we, af_full, wdf_full,
        input  stall, empty, af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en
    );
endinterface

// File: rtl/uncached_write_buffer.sv
// Posted write-combining store buffer: queues line-sized uncached writes and
// drains each as one AF command plus BURST masked WDF beats.
module uncached_write_buffer #(
    parameter int DEPTH = 4,
    parameter int DQ_W  = 128,
    parameter int BURST = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uncached_write_buffer_if.slave bus
);
    localparam int BEAT_BYTES = DQ_W / 8;
    localparam int LINE_BYTES = BEAT_BYTES * BURST;
    localparam int LINE_LSB   = $clog2(LINE_BYTES);
    localparam int TAG_W      = 28 - LINE_LSB;
    localparam int WOFF_W     = LINE_LSB - 2;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int BEAT_W     = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_BEAT = 2'd2;

    logic [TAG_W-1:0]      r_tag  [DEPTH];
    logic [LINE_BYTES-1:0] r_be   [DEPTH];
    logic [7:0]            r_data [DEPTH][LINE_BYTES];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_state;
    logic [BEAT_W-1:0] r_beat;

    logic                  w_valid;
    logic [TAG_W-1:0]      w_tag;
    logic [WOFF_W-1:0]     w_woff;
    logic [PTR_W-1:0]      w_newest;
    logic [PTR_W-1:0]      w_wr_idx;
    logic                  w_merge;
    logic                  w_alloc;
    logic                  w_full;
    logic [LINE_BYTES-1:0] w_store_be;
    logic                  w_cmd_go;
    logic                  w_beat_go;
    logic                  w_pop;
    logic [BEAT_W-1:0]     w_beat_sel;
    logic [DQ_W-1:0]       w_beat_data;
    logic [BEAT_BYTES-1:0] w_beat_mask;
    logic                  w_unused;

    assign w_valid  = |bus.we;
    assign w_tag    = bus.addr[27:LINE_LSB];
    assign w_woff   = bus.addr[LINE_LSB-1:2];
    assign w_newest = r_tail - PTR_W'(1);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_unused = ^{bus.addr[31:28], bus.addr[1:0]};

    // The newest entry stays mergeable until the drain FSM has claimed it.
    assign w_merge  = w_valid && (r_count != '0) &&
                      !((r_state != S_IDLE) && (w_newest == r_head)) &&
                      (r_tag[w_newest] == w_tag);
    // NOTE: stall looks only at the registered count, so a pop in the same
    // cycle never frees a slot for the store presented in that cycle.
    assign w_alloc  = w_valid && !w_merge && !w_full;
    assign w_wr_idx = w_merge ? w_newest : r_tail;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_store_be = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            w_store_be[i] = (WOFF_W'(i / 4) == w_woff) && bus.we[3 - (i % 4)];
        end
    end

    // NOTE: the entry storage has no reset; head/tail/count make stale data unreachable.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[r_tail] <= w_tag;
            r_be[r_tail]  <= w_store_be;
        end else if (w_merge) begin
            r_be[w_newest] <= r_be[w_newest] | w_store_be;
        end
        for (int i = 0; i < LINE_BYTES; i++) begin
            if ((w_alloc || w_merge) && w_store_be[i]) begin
                r_data[w_wr_idx][i] <= bus.din[31 - 8 * (i % 4) -: 8];
            end
        end
    end

    assign w_cmd_go   = (r_state == S_CMD) && !bus.af_full && !bus.wdf_full;
    assign w_beat_go  = (r_state == S_BEAT) && !bus.wdf_full;
    assign w_pop      = w_beat_go && (r_beat == BEAT_W'(BURST - 1));
    assign w_beat_sel = (r_state == S_BEAT) ? r_beat : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            if (w_alloc) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)   r_head <= r_head + PTR_W'(1);
            if (w_alloc && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_alloc && w_pop) r_count <= r_count - CNT_W'(1);

            case (r_state)
                S_IDLE: if (r_count != '0) r_state <= S_CMD;
                S_CMD: begin
                    if (w_cmd_go) begin
                        r_state <= S_BEAT;
                        r_beat  <= BEAT_W'(1);
                    end
                end
                S_BEAT: begin
                    if (w_pop) begin
                        r_beat  <= '0;
                        r_state <= (r_count > CNT_W'(1)) ? S_CMD : S_IDLE;
                    end else if (w_beat_go) begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_beat_data = '0;
        w_beat_mask = '1;
        for (int j = 0; j < BEAT_BYTES; j++) begin
            w_beat_data[DQ_W-1-8*j -: 8] =
                r_data[r_head][LINE_LSB'(int'(w_beat_sel) * BEAT_BYTES + j)];
            w_beat_mask[BEAT_BYTES-1-j] =
                ~r_be[r_head][LINE_LSB'(int'(w_beat_sel) * BEAT_BYTES + j)];
        end
    end

    assign bus.stall        = w_valid && !w_merge && w_full;
    assign bus.empty        = (r_count == '0) && (r_state == S_IDLE);
    assign bus.af_wr_en     = w_cmd_go;
    assign bus.wdf_wr_en    = w_cmd_go || w_beat_go;
    assign bus.af_addr_din  = w_cmd_go ? (31'(r_tag[r_head]) << (LINE_LSB - 3)) : '0;
    assign bus.wdf_din      = bus.wdf_wr_en ? w_beat_data : '0;
    assign bus.wdf_mask_din = bus.wdf_wr_en ? w_beat_mask : '1;
endmodule
